// File: rtl/dac_output_sequencer.sv
// DAC output sequencer: takes one of two sample sources, ramps the DAC
// outputs up to it, tracks it while running, and ramps back to zero
// before the source is switched or the DAC is released.
// The per-cycle output change is limited by 'step'. A step of 0 disables
// that limit, so the output follows the target directly.
module dac_output_sequencer #(
    parameter int DATA_WIDTH = 14,
    parameter int STEP_WIDTH = 14
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  src_sel,
    input  logic [DATA_WIDTH-1:0] src0_a,
    input  logic [DATA_WIDTH-1:0] src0_b,
    input  logic [DATA_WIDTH-1:0] src1_a,
    input  logic [DATA_WIDTH-1:0] src1_b,
    input  logic                  src0_valid,
    input  logic                  src1_valid,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] output_a,
    output logic [DATA_WIDTH-1:0] output_b,
    output logic                  m_axis_tvalid,
    output logic [1:0]            state,
    output logic                  active_sel
);

    // The arithmetic width holds a sign-extended sample or a zero-extended
    // step, with room for one add or subtract.
    localparam int CW = ((DATA_WIDTH > STEP_WIDTH) ? DATA_WIDTH : STEP_WIDTH) + 2;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   out_a_q, out_a_d;
    logic [DATA_WIDTH-1:0]   out_b_q, out_b_d;
    logic                    sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   tgt_a, tgt_b;
    logic                    drop;

    // These signals describe the source that owns the DAC, and the source
    // that is currently requested.
    wire                  act_valid = sel_q ? src1_valid : src0_valid;
    wire [DATA_WIDTH-1:0] act_a     = sel_q ? src1_a : src0_a;
    wire [DATA_WIDTH-1:0] act_b     = sel_q ? src1_b : src0_b;
    wire                  req_valid = src_sel ? src1_valid : src0_valid;

    // Move cur toward tgt by at most stp. The difference is computed one
    // bit wider than a sample, so a full-scale swing cannot wrap. The
    // result never passes the target.
    function automatic logic [DATA_WIDTH-1:0] slew(
        input logic [DATA_WIDTH-1:0] cur,
        input logic [DATA_WIDTH-1:0] tgt,
        input logic [STEP_WIDTH-1:0] stp
    );
        logic signed [DATA_WIDTH:0] diff;
        logic        [DATA_WIDTH:0] mag;
        logic signed [CW-1:0]       cur_x;
        logic signed [CW-1:0]       stp_x;
        logic signed [CW-1:0]       sum;
        logic        [DATA_WIDTH-1:0] res;
        diff  = $signed({tgt[DATA_WIDTH-1], tgt}) - $signed({cur[DATA_WIDTH-1], cur});
        mag   = diff[DATA_WIDTH] ? -diff : diff;
        cur_x = CW'($signed(cur));
        stp_x = $signed(CW'(stp));
        sum   = diff[DATA_WIDTH] ? (cur_x - stp_x) : (cur_x + stp_x);
        if (stp == '0 || CW'(mag) <= CW'(stp)) begin
            res = tgt;
        end else begin
            res = sum[DATA_WIDTH-1:0];
        end
        return res;
    endfunction

    // This block computes the next state, the next outputs and the next
    // owning source. When the sink is not ready, everything holds.
    always_comb begin
        // NOTE: every signal gets a default value before the case. Without
        // these defaults, some paths would leave a signal unassigned, and
        // the tool would infer a latch.
        state_d = state_q;
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        sel_d   = sel_q;
        tgt_a   = '0;
        tgt_b   = '0;
        drop    = 1'b0;
        if (m_axis_tready) begin
            case (state_q)
                ST_OFF: begin
                    out_a_d = '0;
                    out_b_d = '0;
                    if (enable && req_valid) begin
                        state_d = ST_RAMP_UP;
                        sel_d   = src_sel;
                    end
                end
                ST_RAMP_UP, ST_RUN: begin
                    drop = !enable || (src_sel != sel_q) || !act_valid;
                    if (!drop) begin
                        tgt_a = act_a;
                        tgt_b = act_b;
                    end
                    out_a_d = slew(out_a_q, tgt_a, step);
                    out_b_d = slew(out_b_q, tgt_b, step);
                    if (drop) begin
                        state_d = ST_RAMP_DOWN;
                    end else if (state_q == ST_RAMP_UP && out_a_d == tgt_a && out_b_d == tgt_b) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RAMP_DOWN: begin
                    // Changes to enable and src_sel are ignored here until
                    // both outputs are back at zero.
                    if (out_a_q == '0 && out_b_q == '0) begin
                        if (enable && req_valid) begin
                            state_d = ST_RAMP_UP;
                            sel_d   = src_sel;
                        end else begin
                            state_d = ST_OFF;
                        end
                    end else begin
                        out_a_d = slew(out_a_q, '0, step);
                        out_b_d = slew(out_b_q, '0, step);
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // This block holds the state register, the output registers and the
    // owning-source register. Reset is synchronous and takes priority.
    always_ff @(posedge aclk) begin
        // NOTE: non-blocking assignments make all registers update
        // together at the edge. Each register therefore sees the previous
        // values of the others, whatever order the statements are in.
        if (reset) begin
            state_q <= ST_OFF;
            out_a_q <= '0;
            out_b_q <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            sel_q   <= sel_d;
        end
    end

    assign output_a      = out_a_q;
    assign output_b      = out_b_q;
    assign m_axis_tvalid = (state_q != ST_OFF);
    assign state         = state_q;
    assign active_sel    = sel_q;

endmodule

// File: tb/tb_dac_output_sequencer.sv
// Testbench for dac_output_sequencer. It runs directed scenarios and then
// a randomized phase. Each cycle the DUT is compared with an
// integer-arithmetic reference model of the sequencer's behaviour.
module tb_dac_output_sequencer;

    logic               aclk = 1'b0;
    logic               reset;
    logic               enable;
    logic               src_sel;
    logic signed [13:0] src0_a, src0_b, src1_a, src1_b;
    logic               src0_valid, src1_valid;
    logic        [13:0] step;
    logic               m_axis_tready;
    logic        [13:0] output_a, output_b;
    logic               m_axis_tvalid;
    logic        [1:0]  state;
    logic               active_sel;

    int total = 0;
    int bad   = 0;

    // Reference model state. The states are 0=OFF, 1=RAMP_UP, 2=RUN and
    // 3=RAMP_DOWN.
    int m_state = 0;
    int m_a = 0;
    int m_b = 0;
    int m_sel = 0;

    dac_output_sequencer #(.DATA_WIDTH(14), .STEP_WIDTH(14)) dut (
        .aclk          (aclk),
        .reset         (reset),
        .enable        (enable),
        .src_sel       (src_sel),
        .src0_a        (src0_a),
        .src0_b        (src0_b),
        .src1_a        (src1_a),
        .src1_b        (src1_b),
        .src0_valid    (src0_valid),
        .src1_valid    (src1_valid),
        .step          (step),
        .m_axis_tready (m_axis_tready),
        .output_a      (output_a),
        .output_b      (output_b),
        .m_axis_tvalid (m_axis_tvalid),
        .state         (state),
        .active_sel    (active_sel)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int slew_m(input int cur, input int tgt, input int stp);
        int d;
        d = tgt - cur;
        if (stp == 0 || (d < 0 ? -d : d) <= stp) return tgt;
        return (d > 0) ? cur + stp : cur - stp;
    endfunction

    function automatic bit valid_of(input int s);
        return (s != 0) ? src1_valid : src0_valid;
    endfunction

    // Advance the model by one clock edge, using the inputs that are
    // currently applied.
    task automatic model_step();
        int ta, tb, stp;
        bit keep;
        stp = int'(step);
        if (reset) begin
            m_state = 0; m_a = 0; m_b = 0; m_sel = 0;
            return;
        end
        if (!m_axis_tready) return;
        case (m_state)
            0: begin
                m_a = 0; m_b = 0;
                if (enable && valid_of(int'(src_sel))) begin
                    m_state = 1; m_sel = int'(src_sel);
                end
            end
            1, 2: begin
                keep = enable && (int'(src_sel) == m_sel) && valid_of(m_sel);
                ta = !keep ? 0 : (m_sel != 0 ? int'(src1_a) : int'(src0_a));
                tb = !keep ? 0 : (m_sel != 0 ? int'(src1_b) : int'(src0_b));
                m_a = slew_m(m_a, ta, stp);
                m_b = slew_m(m_b, tb, stp);
                if (!keep) m_state = 3;
                else if (m_state == 1 && m_a == ta && m_b == tb) m_state = 2;
            end
            default: begin
                if (m_a == 0 && m_b == 0) begin
                    if (enable && valid_of(int'(src_sel))) begin
                        m_state = 1; m_sel = int'(src_sel);
                    end else begin
                        m_state = 0;
                    end
                end else begin
                    m_a = slew_m(m_a, 0, stp);
                    m_b = slew_m(m_b, 0, stp);
                end
            end
        endcase
    endtask

    // Apply one clock edge, then compare every DUT output with the model.
    task automatic tick(input string tag);
        model_step();
        @(posedge aclk);
        #1;
        check({tag, "/out_a"}, $signed(output_a), m_a);
        check({tag, "/out_b"}, $signed(output_b), m_b);
        check({tag, "/state"}, state, m_state);
        check({tag, "/tvalid"}, m_axis_tvalid, (m_state != 0) ? 1 : 0);
        check({tag, "/sel"}, active_sel, m_sel);
    endtask

    initial begin
        int r;
        logic [31:0] rnd;
        reset = 1'b1; enable = 1'b0; src_sel = 1'b0;
        src0_a = '0; src0_b = '0; src1_a = '0; src1_b = '0;
        src0_valid = 1'b0; src1_valid = 1'b0; step = '0; m_axis_tready = 1'b1;

        // Reset state.
        tick("reset0");
        tick("reset1");
        check("reset_state", state, 0);
        check("reset_tvalid", m_axis_tvalid, 0);

        // Ramp up to 1000/-1000 with a step of 250.
        reset = 1'b0; enable = 1'b1; src0_valid = 1'b1;
        src0_a = 14'sd1000; src0_b = -14'sd1000; step = 14'd250;
        tick("up_enter");
        check("up_enter_state", state, 1);
        tick("up1");
        check("up1_a", $signed(output_a), 250);
        check("up1_b", $signed(output_b), -250);
        for (int i = 0; i < 3; i++) tick("up");
        check("up_final_a", $signed(output_a), 1000);
        check("up_final_b", $signed(output_b), -1000);
        check("up_run", state, 2);

        // Drop enable and ramp down with a step of 300.
        step = 14'd300; enable = 1'b0;
        tick("dn1");
        check("dn1_a", $signed(output_a), 700);
        check("dn1_state", state, 3);
        for (int i = 0; i < 3; i++) tick("dn");
        check("dn_zero_a", $signed(output_a), 0);
        check("dn_zero_b", $signed(output_b), 0);
        tick("dn_off");
        check("dn_off_state", state, 0);
        check("dn_off_tvalid", m_axis_tvalid, 0);

        // Switch source while running: ramp down, hand over, ramp up.
        enable = 1'b1; step = 14'd250;
        for (int i = 0; i < 6; i++) tick("sw_up");
        check("sw_run0", state, 2);
        src1_a = 14'sd500; src1_b = 14'sd500; src1_valid = 1'b1; src_sel = 1'b1;
        for (int i = 0; i < 10; i++) tick("sw");
        check("sw_sel", active_sel, 1);
        check("sw_a", $signed(output_a), 500);
        check("sw_b", $signed(output_b), 500);
        check("sw_run1", state, 2);

        // Unlimited step: a full-scale jump happens in one cycle.
        reset = 1'b1; tick("fs_rst");
        reset = 1'b0; src_sel = 1'b0; step = '0;
        src0_a = -14'sd8192; src0_b = 14'sd0;
        tick("fs_enter");
        tick("fs_low");
        check("fs_low_a", $signed(output_a), -8192);
        check("fs_low_state", state, 2);
        src0_a = 14'sd8191;
        tick("fs_jump");
        check("fs_jump_a", $signed(output_a), 8191);

        // A step of 1000 across full scale takes 17 steps, without overshoot.
        src0_a = -14'sd8192; tick("slew_reset_low");
        step = 14'd1000; src0_a = 14'sd8191;
        for (int i = 0; i < 16; i++) tick("slew");
        check("slew16_a", $signed(output_a), 7808);
        tick("slew17");
        check("slew17_a", $signed(output_a), 8191);
        tick("slew18");
        check("slew18_a", $signed(output_a), 8191);

        // Stall the sink during a ramp-down, then assert reset mid-ramp.
        step = 14'd100; enable = 1'b0;
        tick("st1"); tick("st2");
        check("st_pre_a", $signed(output_a), 7991);
        m_axis_tready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            check("stall_a", $signed(output_a), 7991);
            check("stall_state", state, 3);
        end
        m_axis_tready = 1'b1;
        tick("st_resume");
        check("st_resume_a", $signed(output_a), 7891);
        reset = 1'b1;
        tick("mid_rst");
        check("mid_rst_state", state, 0);
        check("mid_rst_a", $signed(output_a), 0);
        reset = 1'b0;
        tick("post_rst");
        check("post_rst_state", state, 1);

        // Randomized phase.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            enable = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 29) == 0) src_sel = ~src_sel;
            src0_valid = ($urandom_range(0, 24) != 0);
            src1_valid = ($urandom_range(0, 24) != 0);
            m_axis_tready = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) begin
                rnd = $urandom; src0_a = rnd[13:0]; src0_b = rnd[27:14];
                rnd = $urandom; src1_a = rnd[13:0]; src1_b = rnd[27:14];
            end
            if ($urandom_range(0, 15) == 0) begin
                r = int'($urandom_range(0, 3));
                case (r)
                    0: step = '0;
                    1: step = 14'($urandom_range(1, 50));
                    2: step = 14'($urandom_range(500, 3000));
                    default: step = 14'd16383;
                endcase
            end
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
